data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and transaction sequencer in front of the stall-based data memory (`data_mem`). It shares the single memory port between the CPU load/store unit and a DMA/debug requester. It converts each granted request into a one-cycle `memread`/`memwrite` strobe, tracks the memory's `clk_stall` busy window, and returns a per-port completion pulse with captured read data. A watchdog aborts transactions whose stall handshake never completes.

## Interface
- `TIMEOUT_CYCLES`, 16: max WAIT cycles before abort (≥2, counter width `$clog2(TIMEOUT_CYCLES+1)`).
- `clk`  in  1  single system clock, all logic on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cpu_req` / `dma_req`  in  1  request; held with fields stable until that port's `*_done`.
- `cpu_we` / `dma_we`  in  1  1 = store, 0 = load.
- `cpu_addr` / `dma_addr`  in  32  byte address.
- `cpu_wdata` / `dma_wdata`  in  32  store data.
- `cpu_sign_mask` / `dma_sign_mask`  in  4  access size/sign code, passed through unmodified.
- `cpu_gnt` / `dma_gnt`  out  1  high during the ISSUE cycle of that port's transaction.
- `cpu_done` / `dma_done`  out  1  one-cycle completion pulse.
- `cpu_rdata` / `dma_rdata`  out  32  load result; held until that port's next completion.
- `mem_addr`, `mem_write_data`  out  32  to memory.
- `mem_memread`, `mem_memwrite`  out  1  one-cycle strobes.
- `mem_sign_mask`  out  4  to memory.
- `mem_read_data`  in  32  from memory.
- `mem_clk_stall`  in  1  memory busy.
- `timeout_err`  out  1  sticky abort flag; cleared only by reset.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also sets state=IDLE, the RR pointer to "DMA last", the timeout counter to 0, and `seen_stall` to 0.
- IDLE: if any `*_req`, pick the winner, latch its fields into `mem_*` with the strobe (`we` ? `mem_memwrite` : `mem_memread`), assert its `*_gnt`, and go to ISSUE.
- ISSUE (1 cycle): strobes and gnt are high. Next state is WAIT. Strobes and gnt drop on exit. `mem_addr`/`mem_write_data`/`mem_sign_mask` hold until the next ISSUE.
- WAIT: set `seen_stall` when `mem_clk_stall`=1. Exit to RESP when `mem_clk_stall`=0 and `seen_stall`=1. For loads, capture `mem_read_data` into the winner's rdata on that exit edge.
- The timeout counter increments each WAIT cycle. When it reaches `TIMEOUT_CYCLES`, go to RESP as an abort: set `timeout_err`, write rdata=32'h0 for loads.
- RESP (1 cycle): winner's `*_done`=1. Clear the counter and `seen_stall`. Next state is IDLE.
- Requests arriving outside IDLE wait. The losing requester's request stays pending, with no gnt or done.
- Requester must drop or replace `req` at the edge after `done`. A `req` still high in IDLE is a new transaction.
- Store completion is valid once stall falls. The arbiter does not check the written data.

## Timing
- Cycle t: IDLE samples `req`.
- Cycle t+1: ISSUE, strobe high.
- Cycle t+2: memory stall expected high.
- Minimum latency for a single-cycle memory stall: stall low at t+3, `done` at t+4, `rdata` valid at t+4.
- Back-to-back throughput: one transaction per 5 cycles minimum (RESP→IDLE→ISSUE).
- Stall never rising: abort with `done` at t+2+`TIMEOUT_CYCLES`.
- Stall rising then stuck high: same abort bound.
- `rst_n` low mid-transaction: next edge goes to IDLE with all outputs 0. No `done` is issued for the abandoned transaction, and `timeout_err` clears.

## Configuration
- `DATA_MEM_ARB_RR_EN` defined: round-robin. When both request in IDLE, the port not granted last wins. With a single requester, that port wins and the pointer updates to it.
- `DATA_MEM_ARB_RR_EN` undefined: fixed priority, CPU always beats DMA. No pointer register is present.

## Structure
- Package `data_mem_arb_pkg` holds:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - port-select enum (CPU, DMA)
  - `ABORT_RDATA`=32'h0
  - default `TIMEOUT_CYCLES`
- Sub-module `data_mem_arb_pick`: combinational winner select plus the RR pointer register (pointer present only under `DATA_MEM_ARB_RR_EN`).
- Top level holds the FSM, the field latch, the watchdog, and the rdata registers.

## Test plan
- CPU load from 0x1004, memory stalls 1 cycle returning 0x12345678 → `cpu_gnt` at t+1, `cpu_done` at t+4, `cpu_rdata`=0x12345678, `dma_*` silent.
- Both ports request loads at the same cycle, with 3 back-to-back pairs:
  - RR build: grant order CPU, DMA, CPU, DMA, CPU, DMA.
  - Fixed build: CPU served every time DMA competes.
- DMA store 0xCAFEF00D to 0x1010, sign_mask 4'b0100 → one-cycle `mem_memwrite` with matching addr/data/mask, `dma_done` after stall falls, `dma_rdata` unchanged.
- Memory never asserts stall, `TIMEOUT_CYCLES`=4 → `cpu_done` at t+6 with `cpu_rdata`=0, `timeout_err`=1 and stays set through later good transactions.
- `rst_n` low during WAIT → next cycle all outputs 0, no `done`. A fresh CPU request after release completes normally.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and constants for the data memory arbiter.
//   state_e  : transaction sequencer states (IDLE, ISSUE, WAIT, RESP)
//   port_e   : requester select (CPU, DMA)
//   req_t    : one requester's transaction fields as presented to memory
//   ABORT_RDATA            : load result returned when the watchdog aborts
//   DEFAULT_TIMEOUT_CYCLES : default WAIT budget before abort
// The arbitration policy is chosen by DATA_MEM_ARB_RR_EN (see data_mem_arb_pick).
package data_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    CPU,
    DMA
  } port_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sign_mask;
  } req_t;

  localparam logic [31:0] ABORT_RDATA            = 32'h0;
  localparam int          DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/data_mem_arb_pick.sv
// Winner select for the two requesters.
//   clk, rst_n : clock and synchronous active-low reset (pointer register only)
//   cpu_req    : CPU load/store unit request
//   dma_req    : DMA/debug request
//   take       : a grant is issued this cycle; the pointer follows the winner
//   winner     : port that wins if a grant is taken now
//   any_req    : at least one port is requesting
// Build option DATA_MEM_ARB_RR_EN: defined -> round-robin with a "last granted"
// pointer that resets to DMA; undefined -> fixed priority, CPU over DMA, no pointer.
module data_mem_arb_pick
  import data_mem_arb_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  cpu_req,
  input  logic  dma_req,
  input  logic  take,
  output port_e winner,
  output logic  any_req
);

  assign any_req = cpu_req | dma_req;

`ifdef DATA_MEM_ARB_RR_EN
  port_e last_q, last_d;

  always_comb begin
    winner = CPU;
    if (cpu_req && dma_req) begin
      // Contention: the port that was not granted last goes first.
      if (last_q == CPU) winner = DMA;
      else               winner = CPU;
    end else if (dma_req) begin
      winner = DMA;
    end

    last_d = last_q;
    if (take) last_d = winner;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= DMA;
    else        last_q <= last_d;
  end
`else
  always_comb begin
    winner = CPU;
    if (!cpu_req && dma_req) winner = DMA;
  end

  // Clock, reset and take only feed the pointer of the round-robin build.
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, take};
`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and transaction sequencer in front of the stall-based data memory.
// Shares the single memory port between the CPU and a DMA/debug requester, issues a
// one-cycle memread/memwrite strobe per grant, tracks the memory's clk_stall busy
// window and returns a per-port done pulse with captured load data. A watchdog
// aborts a transaction after TIMEOUT_CYCLES WAIT cycles and sets sticky timeout_err.
// Ports:
//   clk, rst_n                        : clock, synchronous active-low reset
//   cpu_*/dma_* req,we,addr,wdata,sign_mask : request side, held until *_done
//   cpu_gnt/dma_gnt                   : high during the ISSUE cycle of that port
//   cpu_done/dma_done                 : one-cycle completion pulse
//   cpu_rdata/dma_rdata               : load result, held until the next completion
//   mem_addr, mem_write_data, mem_sign_mask, mem_memread, mem_memwrite : to memory
//   mem_read_data, mem_clk_stall      : from memory
//   timeout_err                       : sticky abort flag, cleared by reset only
// Build option DATA_MEM_ARB_RR_EN selects round-robin instead of CPU-first priority.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_sign_mask,
  output logic        cpu_gnt,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_sign_mask,
  output logic        dma_gnt,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall,
  output logic        timeout_err
);

  localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  port_e             sel_q, sel_d;
  logic              seen_stall_q, seen_stall_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              mem_q, mem_d;
  logic              memread_q, memread_d;
  logic              memwrite_q, memwrite_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dma_gnt_q, dma_gnt_d;
  logic              cpu_done_q, cpu_done_d;
  logic              dma_done_q, dma_done_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       dma_rdata_q, dma_rdata_d;
  logic              timeout_err_q, timeout_err_d;

  req_t        cpu_fields, dma_fields;
  port_e       winner;
  logic        any_req;
  logic        take;
  logic        txn_end;
  logic        txn_abort;
  logic [31:0] load_result;

  assign cpu_fields = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, sign_mask: cpu_sign_mask};
  assign dma_fields = '{we: dma_we, addr: dma_addr, wdata: dma_wdata, sign_mask: dma_sign_mask};

  // A grant is only taken from IDLE; requests seen in any other state just wait.
  assign take = (state_q == IDLE) && any_req;

  data_mem_arb_pick u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .take    (take),
    .winner  (winner),
    .any_req (any_req)
  );

  // NOTE: every variable gets its hold/idle value before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    seen_stall_d  = seen_stall_q;
    cnt_d         = cnt_q;
    mem_d         = mem_q;
    memread_d     = 1'b0;
    memwrite_d    = 1'b0;
    cpu_gnt_d     = 1'b0;
    dma_gnt_d     = 1'b0;
    cpu_done_d    = 1'b0;
    dma_done_d    = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    dma_rdata_d   = dma_rdata_q;
    timeout_err_d = timeout_err_q;
    txn_end       = 1'b0;
    txn_abort     = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d = winner;
          if (winner == CPU) begin
            mem_d     = cpu_fields;
            cpu_gnt_d = 1'b1;
          end else begin
            mem_d     = dma_fields;
            dma_gnt_d = 1'b1;
          end
          memwrite_d = mem_d.we;
          memread_d  = !mem_d.we;
          state_d    = ISSUE;
        end
      end

      ISSUE: state_d = WAIT;

      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_clk_stall) seen_stall_d = 1'b1;
        // Completion is the falling edge of a stall we actually observed; a memory
        // that has not yet raised stall is still busy, not finished.
        if (!mem_clk_stall && seen_stall_q) begin
          txn_end = 1'b1;
        end else if (cnt_d == CNT_MAX) begin
          txn_end   = 1'b1;
          txn_abort = 1'b1;
        end
      end

      RESP: begin
        cnt_d        = '0;
        seen_stall_d = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase

    load_result = txn_abort ? ABORT_RDATA : mem_read_data;

    if (txn_end) begin
      state_d = RESP;
      if (txn_abort) timeout_err_d = 1'b1;
      if (sel_q == CPU) begin
        cpu_done_d = 1'b1;
        if (!mem_q.we) cpu_rdata_d = load_result;
      end else begin
        dma_done_d = 1'b1;
        if (!mem_q.we) dma_rdata_d = load_result;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers (memory fields, rdata) are reset as well, because
    // every output must read 0 straight out of reset, including mid-transaction.
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= CPU;
      seen_stall_q  <= 1'b0;
      cnt_q         <= '0;
      mem_q         <= '0;
      memread_q     <= 1'b0;
      memwrite_q    <= 1'b0;
      cpu_gnt_q     <= 1'b0;
      dma_gnt_q     <= 1'b0;
      cpu_done_q    <= 1'b0;
      dma_done_q    <= 1'b0;
      cpu_rdata_q   <= '0;
      dma_rdata_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      seen_stall_q  <= seen_stall_d;
      cnt_q         <= cnt_d;
      mem_q         <= mem_d;
      memread_q     <= memread_d;
      memwrite_q    <= memwrite_d;
      cpu_gnt_q     <= cpu_gnt_d;
      dma_gnt_q     <= dma_gnt_d;
      cpu_done_q    <= cpu_done_d;
      dma_done_q    <= dma_done_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dma_rdata_q   <= dma_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cpu_gnt        = cpu_gnt_q;
  assign dma_gnt        = dma_gnt_q;
  assign cpu_done       = cpu_done_q;
  assign dma_done       = dma_done_q;
  assign cpu_rdata      = cpu_rdata_q;
  assign dma_rdata      = dma_rdata_q;
  assign mem_addr       = mem_q.addr;
  assign mem_write_data = mem_q.wdata;
  assign mem_sign_mask  = mem_q.sign_mask;
  assign mem_memread    = memread_q;
  assign mem_memwrite   = memwrite_q;
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter (TIMEOUT_CYCLES = 4).
// A behavioural stall memory answers each strobe; each stimulus task pushes the
// expected completion into a scoreboard queue and a separate monitor pops and
// compares whenever a done pulse appears. The expected grant order of the
// contention test follows DATA_MEM_ARB_RR_EN.
module tb_data_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [3:0]  cpu_sign_mask, dma_sign_mask;
  logic        cpu_gnt, cpu_done, dma_gnt, dma_done;
  logic [31:0] cpu_rdata, dma_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memread, mem_memwrite, mem_clk_stall;
  logic [3:0]  mem_sign_mask;
  logic        timeout_err;

  always #5 clk = ~clk;

  data_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_sign_mask  (cpu_sign_mask),
    .cpu_gnt        (cpu_gnt),
    .cpu_done       (cpu_done),
    .cpu_rdata      (cpu_rdata),
    .dma_req        (dma_req),
    .dma_we         (dma_we),
    .dma_addr       (dma_addr),
    .dma_wdata      (dma_wdata),
    .dma_sign_mask  (dma_sign_mask),
    .dma_gnt        (dma_gnt),
    .dma_done       (dma_done),
    .dma_rdata      (dma_rdata),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_memread    (mem_memread),
    .mem_memwrite   (mem_memwrite),
    .mem_sign_mask  (mem_sign_mask),
    .mem_read_data  (mem_read_data),
    .mem_clk_stall  (mem_clk_stall),
    .timeout_err    (timeout_err)
  );

  typedef struct {
    logic        is_dma;
    logic [31:0] rdata;
    logic        terr;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          stall_len = 1;   // 0: stall never rises; large: stall stuck high
  int          stall_cnt;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] cpu_last = '0;
  logic [31:0] dma_last = '0;
  logic        terr_exp = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [138:0] out_vec();
    return {cpu_gnt, dma_gnt, cpu_done, dma_done, cpu_rdata, dma_rdata, mem_addr,
            mem_write_data, mem_memread, mem_memwrite, mem_sign_mask, timeout_err};
  endfunction

  function automatic void push_exp(input logic is_dma, input logic [31:0] rdata);
    exp_t e;
    e.is_dma = is_dma;
    e.rdata  = rdata;
    e.terr   = terr_exp;
    sb.push_back(e);
  endfunction

  // Behavioural stall memory: a strobe raises stall for stall_len cycles.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem_clk_stall <= 1'b0;
      stall_cnt     <= 0;
    end else if (mem_memread || mem_memwrite) begin
      mem_read_data <= rd_model(mem_addr);
      if (stall_len > 0) begin
        mem_clk_stall <= 1'b1;
        stall_cnt     <= stall_len;
      end
    end else if (stall_cnt > 0) begin
      stall_cnt <= stall_cnt - 1;
      if (stall_cnt == 1) mem_clk_stall <= 1'b0;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (cpu_done || dma_done) begin
      exp_t e;
      check("single_done", cpu_done & dma_done, 0);
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("done_port", dma_done, e.is_dma);
        check("done_rdata", dma_done ? dma_rdata : cpu_rdata, e.rdata);
        check("done_terr", timeout_err, e.terr);
      end
    end
  end

  task automatic single(input logic is_dma, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        input bit abort, input int exp_lat);
    logic [31:0] exp_rd;
    int          n;
    @(negedge clk);
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata; dma_sign_mask = mask;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_sign_mask = mask;
    end
    if (abort) terr_exp = 1'b1;
    if (we) exp_rd = is_dma ? dma_last : cpu_last;
    else    exp_rd = abort ? 32'h0 : rd_model(addr);
    if (is_dma) dma_last = exp_rd;
    else        cpu_last = exp_rd;
    push_exp(is_dma, exp_rd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("gnt_own",   is_dma ? dma_gnt : cpu_gnt, 1);
        check("gnt_other", is_dma ? cpu_gnt : dma_gnt, 0);
        check("memread",   mem_memread, !we);
        check("memwrite",  mem_memwrite, we);
        check("mem_addr",  mem_addr, addr);
        check("mem_wdata", mem_write_data, wdata);
        check("mem_mask",  mem_sign_mask, mask);
      end
      if (n == 2) check("strobe_drop", {cpu_gnt, dma_gnt, mem_memread, mem_memwrite}, 0);
    end while (!(is_dma ? dma_done : cpu_done) && n < 40);
    check("latency", n, exp_lat);
    if (is_dma) dma_req = 1'b0;
    else        cpu_req = 1'b0;
  endtask

  // Both ports keep three loads each queued back to back.
  task automatic stream();
    int ci = 0;
    int di = 0;
    int budget = 0;
`ifdef DATA_MEM_ARB_RR_EN
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, rd_model(32'h2000 + 32'(i * 4)));
      push_exp(1'b1, rd_model(32'h3000 + 32'(i * 4)));
    end
`else
    for (int i = 0; i < 3; i++) push_exp(1'b0, rd_model(32'h2000 + 32'(i * 4)));
    for (int i = 0; i < 3; i++) push_exp(1'b1, rd_model(32'h3000 + 32'(i * 4)));
`endif
    cpu_last = rd_model(32'h2008);
    dma_last = rd_model(32'h3008);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h2000; cpu_sign_mask = 4'b0010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h3000; dma_sign_mask = 4'b0010;
    while ((ci < 3 || di < 3) && budget < 200) begin
      @(negedge clk);
      budget++;
      if (cpu_done) begin
        ci++;
        if (ci < 3) cpu_addr = 32'h2000 + 32'(ci * 4);
        else        cpu_req  = 1'b0;
      end
      if (dma_done) begin
        di++;
        if (di < 3) dma_addr = 32'h3000 + 32'(di * 4);
        else        dma_req  = 1'b0;
      end
    end
    check("stream_all_done", {ci[3:0], di[3:0]}, {4'd3, 4'd3});
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_sign_mask = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0; dma_sign_mask = '0;
    mem_read_data = '0;
    mem[32'h1004] = 32'h1234_5678;

    repeat (2) @(negedge clk);
    check("reset_outputs", out_vec(), 0);
    rst_n = 1'b1;

    // CPU load, one-cycle stall.
    stall_len = 1;
    single(1'b0, 1'b0, 32'h1004, 32'h0, 4'b0010, 1'b0, 4);

    // DMA store, two-cycle stall; dma_rdata must stay 0.
    stall_len = 2;
    single(1'b1, 1'b1, 32'h1010, 32'hCAFE_F00D, 4'b0100, 1'b0, 5);

    // Contention: grant order depends on the arbitration build.
    stall_len = 1;
    stream();

    // Stall never rises: abort at t+2+TO.
    stall_len = 0;
    single(1'b0, 1'b0, 32'h1020, 32'h0, 4'b0010, 1'b1, 2 + TO);

    // Stall rises and sticks: same bound, DMA load result forced to 0.
    stall_len = 1000;
    single(1'b1, 1'b0, 32'h1030, 32'h0, 4'b0001, 1'b1, 2 + TO);

    // Good transaction afterwards: timeout_err stays set.
    stall_len = 1;
    single(1'b0, 1'b0, 32'h1004, 32'h0, 4'b0010, 1'b0, 4);

    // Reset while WAITing: abandoned transaction produces no done.
    @(negedge clk);
    stall_len = 1000;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1040; cpu_wdata = '0; cpu_sign_mask = 4'b0010;
    repeat (3) @(negedge clk);
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", out_vec(), 0);
    cpu_last = '0;
    dma_last = '0;
    terr_exp = 1'b0;
    rst_n     = 1'b1;
    stall_len = 1;
    single(1'b0, 1'b0, 32'h1040, 32'h0, 4'b0010, 1'b0, 4);

    repeat (6) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
